// File: rtl/mux_sel_arbiter.sv
// Two-source round-robin arbiter driving a 2:1 mux select.
// Each grant is held for at most HOLD cycles while the other source waits.
module mux_sel_arbiter #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req1,
    input  logic req2,
    output logic g1,
    output logic g2,
    output logic s,
    output logic sw
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } state_t;

    localparam logic [7:0] HMAX = 8'(HOLD - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       last, last_n;
    logic       s_n, sw_n;
    logic       go1, go2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            last  <= 1'b0;
            s     <= 1'b0;
            sw    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            last  <= last_n;
            s     <= s_n;
            sw    <= sw_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last;
        s_n     = s;
        sw_n    = 1'b0;
        go1     = 1'b0;
        go2     = 1'b0;

        case (state)
            IDLE: begin
                if (req1 && req2) begin
                    go1 = !last;
                    go2 = last;
                end else begin
                    go1 = req1;
                    go2 = req2;
                end
            end
            GNT1: begin
                if (!req1) begin
                    go2 = req2;
                    if (!req2) state_n = IDLE;
                end else if (cnt != HMAX) begin
                    cnt_n = cnt + 8'd1;
                end else if (req2) begin
                    go2 = 1'b1;
                end else begin
                    cnt_n = 8'd0;
                end
            end
            GNT2: begin
                if (!req2) begin
                    go1 = req1;
                    if (!req1) state_n = IDLE;
                end else if (cnt != HMAX) begin
                    cnt_n = cnt + 8'd1;
                end else if (req1) begin
                    go1 = 1'b1;
                end else begin
                    cnt_n = 8'd0;
                end
            end
            default: state_n = IDLE;
        endcase

        // a new grant restarts the hold window and flags the switch
        if (go1 || go2) begin
            state_n = go1 ? GNT1 : GNT2;
            cnt_n   = 8'd0;
            last_n  = go1;
            s_n     = go1;
            sw_n    = 1'b1;
        end else if (state_n == IDLE) begin
            cnt_n = 8'd0;
        end
    end

    assign g1 = (state == GNT1);
    assign g2 = (state == GNT2);

endmodule
